// File: rtl/mem_handle_cache.sv
// mem_handle_cache: single-line write-back cache between one mem_handle
// requester and a backing memory controller. One line of 2**CACHE_BITS
// words with a per-word dirty bit; per-request write-through and
// read-through bypass; flush writes back dirty words and invalidates.
// Memory operations are strictly sequential with one outstanding request.
// A request is also taken in the RESP cycle because avail is already high
// there, so a requester that trusts avail never loses a request.
module mem_handle_cache #(
  parameter int ADDR_SIZE  = 23,
  parameter int DATA_SIZE  = 32,
  parameter int CACHE_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] h_region_begin,
  input  logic [ADDR_SIZE-1:0] h_region_end,
  input  logic [ADDR_SIZE-1:0] h_ptr,
  input  logic                 h_r_en,
  input  logic                 h_w_en,
  input  logic                 h_write_through,
  input  logic                 h_read_through,
  input  logic [DATA_SIZE-1:0] h_data_store,
  input  logic                 h_flush,
  output logic                 h_avail,
  output logic                 h_done,
  output logic                 h_err,
  output logic [DATA_SIZE-1:0] h_data_load,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack
);

  localparam int LINE_WORDS = 1 << CACHE_BITS;
  localparam int TAG_BITS   = ADDR_SIZE - CACHE_BITS;

  localparam logic [CACHE_BITS-1:0] LAST_WORD = '1;
  localparam logic [CACHE_BITS-1:0] WORD_ZERO = '0;
  localparam logic [LINE_WORDS-1:0] BIT_ZERO  = {{(LINE_WORDS-1){1'b0}}, 1'b1};

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WB   = 3'd1;
  localparam logic [2:0] FILL = 3'd2;
  localparam logic [2:0] MRD  = 3'd3;
  localparam logic [2:0] MWR  = 3'd4;
  localparam logic [2:0] RESP = 3'd5;

  logic [2:0]            state;
  logic [DATA_SIZE-1:0]  line_data [LINE_WORDS];
  logic [LINE_WORDS-1:0] dirty;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;

  logic [TAG_BITS-1:0]   req_tag;
  logic [CACHE_BITS-1:0] req_word;
  logic [DATA_SIZE-1:0]  req_data;
  logic                  req_is_flush;
  logic                  req_is_write;
  logic [CACHE_BITS-1:0] fill_idx;
  logic                  err_flag;

  logic [TAG_BITS-1:0]   ptr_tag;
  logic [CACHE_BITS-1:0] ptr_word;
  logic                  in_region;
  logic                  ptr_hit;
  logic                  any_dirty;
  logic                  can_accept;
  logic                  new_req;
  logic                  ack_valid;
  logic [CACHE_BITS-1:0] wb_idx;
  logic [LINE_WORDS-1:0] dirty_rest;
  logic [CACHE_BITS-1:0] wb_next_idx;
  logic [CACHE_BITS-1:0] fill_next_idx;

  // Lowest set bit of a dirty mask; write-back walks the line in ascending order.
  function automatic logic [CACHE_BITS-1:0] first_set(input logic [LINE_WORDS-1:0] vec);
    logic [CACHE_BITS-1:0] idx;
    idx = '0;
    for (int i = LINE_WORDS - 1; i >= 0; i--) begin
      if (vec[i]) idx = CACHE_BITS'(i);
    end
    return idx;
  endfunction

  // Request decode, hit detection and write-back / fill sequencing helpers.
  always_comb begin
    ptr_tag       = h_ptr[ADDR_SIZE-1:CACHE_BITS];
    ptr_word      = h_ptr[CACHE_BITS-1:0];
    in_region     = (h_ptr >= h_region_begin) && (h_ptr < h_region_end);
    ptr_hit       = line_valid && (line_tag == ptr_tag);
    any_dirty     = |dirty;
    can_accept    = (state == IDLE) || (state == RESP);
    new_req       = can_accept && (h_r_en || h_w_en || h_flush);
    ack_valid     = mem_ack && (mem_rd || mem_wr);
    wb_idx        = first_set(dirty);
    dirty_rest    = dirty & ~(BIT_ZERO << wb_idx);
    wb_next_idx   = first_set(dirty_rest);
    fill_next_idx = fill_idx + 1'b1;
  end

  // Requester-facing status is decoded straight from the state register.
  always_comb begin
    h_avail = can_accept;
    h_done  = (state == RESP);
    h_err   = (state == RESP) && err_flag;
  end

  // Main controller: accepts requests, runs write-back, fill and bypass
  // memory operations, and maintains the line contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dirty        <= '0;
      line_valid   <= 1'b0;
      line_tag     <= '0;
      req_tag      <= '0;
      req_word     <= '0;
      req_data     <= '0;
      req_is_flush <= 1'b0;
      req_is_write <= 1'b0;
      fill_idx     <= '0;
      err_flag     <= 1'b0;
      h_data_load  <= '0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
      for (int i = 0; i < LINE_WORDS; i++) line_data[i] <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          state    <= IDLE;
          err_flag <= 1'b0;
          if (new_req) begin
            req_tag      <= ptr_tag;
            req_word     <= ptr_word;
            req_data     <= h_data_store;
            req_is_flush <= h_flush;
            req_is_write <= !h_flush && h_w_en;
            if (h_flush) begin
              if (any_dirty) begin
                mem_addr  <= {line_tag, wb_idx};
                mem_wdata <= line_data[wb_idx];
                mem_wr    <= 1'b1;
                state     <= WB;
              end else begin
                line_valid <= 1'b0;
                state      <= RESP;
              end
            end else if (!in_region) begin
              err_flag <= 1'b1;
              state    <= RESP;
            end else if (h_w_en) begin
              if (h_write_through) begin
                if (ptr_hit) begin
                  line_data[ptr_word] <= h_data_store;
                  dirty[ptr_word]     <= 1'b0;
                end
                mem_addr  <= h_ptr;
                mem_wdata <= h_data_store;
                mem_wr    <= 1'b1;
                state     <= MWR;
              end else if (ptr_hit) begin
                line_data[ptr_word] <= h_data_store;
                dirty[ptr_word]     <= 1'b1;
                state               <= RESP;
              end else if (any_dirty) begin
                mem_addr  <= {line_tag, wb_idx};
                mem_wdata <= line_data[wb_idx];
                mem_wr    <= 1'b1;
                state     <= WB;
              end else begin
                mem_addr   <= {ptr_tag, WORD_ZERO};
                mem_rd     <= 1'b1;
                fill_idx   <= '0;
                line_valid <= 1'b0;
                state      <= FILL;
              end
            end else begin
              if (h_read_through) begin
                if (ptr_hit && dirty[ptr_word]) begin
                  h_data_load <= line_data[ptr_word];
                  state       <= RESP;
                end else begin
                  mem_addr <= h_ptr;
                  mem_rd   <= 1'b1;
                  state    <= MRD;
                end
              end else if (ptr_hit) begin
                h_data_load <= line_data[ptr_word];
                state       <= RESP;
              end else if (any_dirty) begin
                mem_addr  <= {line_tag, wb_idx};
                mem_wdata <= line_data[wb_idx];
                mem_wr    <= 1'b1;
                state     <= WB;
              end else begin
                mem_addr   <= {ptr_tag, WORD_ZERO};
                mem_rd     <= 1'b1;
                fill_idx   <= '0;
                line_valid <= 1'b0;
                state      <= FILL;
              end
            end
          end
        end

        WB: begin
          if (ack_valid) begin
            dirty[wb_idx] <= 1'b0;
            if (|dirty_rest) begin
              mem_addr  <= {line_tag, wb_next_idx};
              mem_wdata <= line_data[wb_next_idx];
            end else begin
              mem_wr <= 1'b0;
              if (req_is_flush) begin
                line_valid <= 1'b0;
                state      <= RESP;
              end else begin
                mem_addr   <= {req_tag, WORD_ZERO};
                mem_rd     <= 1'b1;
                fill_idx   <= '0;
                line_valid <= 1'b0;
                state      <= FILL;
              end
            end
          end
        end

        FILL: begin
          if (ack_valid) begin
            line_data[fill_idx] <= mem_rdata;
            if (fill_idx == LAST_WORD) begin
              mem_rd     <= 1'b0;
              line_valid <= 1'b1;
              line_tag   <= req_tag;
              dirty      <= '0;
              state      <= RESP;
              if (req_is_write) begin
                line_data[req_word] <= req_data;
                dirty[req_word]     <= 1'b1;
              end else begin
                h_data_load <= (req_word == LAST_WORD) ? mem_rdata : line_data[req_word];
              end
            end else begin
              fill_idx <= fill_next_idx;
              mem_addr <= {req_tag, fill_next_idx};
            end
          end
        end

        MRD: begin
          if (ack_valid) begin
            mem_rd      <= 1'b0;
            h_data_load <= mem_rdata;
            state       <= RESP;
          end
        end

        MWR: begin
          if (ack_valid) begin
            mem_wr <= 1'b0;
            state  <= RESP;
          end
        end

        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule
